// File: rtl/burst_load_mem.sv
// Byte-addressed unified memory with NUM_RD_PORTS CPU read ports, one CPU write port and an HTIF burst-load engine.
// Latency: writes commit on posedge clk; reads are combinational (RD_LATENCY=0) or registered, read-first (RD_LATENCY=1).
// Backpressure: hw_ready drops whenever dw_en is high, so a CPU write always wins over an HTIF beat.
//
// Ports:
//   clk, reset_n                   clock and async active-low reset
//   hw_start/hw_base_addr/hw_len   burst launch (sampled in IDLE only)
//   hw_valid/hw_ready/hw_data/hw_mask  beat handshake, byte i -> ptr+i
//   hw_busy/hw_done                burst in progress / 1-cycle completion pulse
//   hr_addr/hr_data                HTIF read port
//   dw_en/dw_addr/dw_data/dw_mask  CPU write port
//   rd_addr/rd_data                packed CPU read ports, port p at [p*W +: W]
module burst_load_mem #(
  parameter int NUM_BYTES       = (1 << 21),
  parameter int DATA_WIDTH_HTIF = 64,
  parameter int DATA_WIDTH_CPU  = 32,
  parameter int NUM_RD_PORTS    = 2,
  parameter int RD_LATENCY      = 0,
  parameter int LEN_WIDTH       = 16,
  localparam int ADDR_WIDTH     = $clog2(NUM_BYTES),
  localparam int MH             = DATA_WIDTH_HTIF / 8,
  localparam int MC             = DATA_WIDTH_CPU / 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   hw_start,
  input  logic [ADDR_WIDTH-1:0]                  hw_base_addr,
  input  logic [LEN_WIDTH-1:0]                   hw_len,
  input  logic                                   hw_valid,
  output logic                                   hw_ready,
  input  logic [DATA_WIDTH_HTIF-1:0]             hw_data,
  input  logic [MH-1:0]                          hw_mask,
  output logic                                   hw_busy,
  output logic                                   hw_done,
  input  logic [ADDR_WIDTH-1:0]                  hr_addr,
  output logic [DATA_WIDTH_HTIF-1:0]             hr_data,
  input  logic                                   dw_en,
  input  logic [ADDR_WIDTH-1:0]                  dw_addr,
  input  logic [DATA_WIDTH_CPU-1:0]              dw_data,
  input  logic [MC-1:0]                          dw_mask,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]     rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH_CPU-1:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  beat_acc;

  // Byte array; deliberately not reset so a reset mid-burst keeps beats already written.
  logic [7:0] mem [NUM_BYTES];

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    hw_ready = 1'b0;
    hw_busy  = 1'b0;
    hw_done  = 1'b0;
    beat_acc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hw_start) begin
          if (hw_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BURST;
            ptr_d   = hw_base_addr;
            cnt_d   = hw_len;
          end
        end
      end
      S_BURST: begin
        hw_busy  = 1'b1;
        hw_ready = ~dw_en;
        beat_acc = hw_valid & ~dw_en;
        if (beat_acc) begin
          // Pointer width equals the address width, so the add wraps mod NUM_BYTES.
          ptr_d = ptr_q + ADDR_WIDTH'(MH);
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        hw_done = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write path: CPU write and HTIF beat are mutually exclusive through ready gating.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (dw_en) begin
      for (int i = 0; i < MC; i++) begin
        if (dw_mask[i]) begin
          mem[dw_addr + ADDR_WIDTH'(i)] <= dw_data[8*i +: 8];
        end
      end
    end
    if (beat_acc) begin
      for (int i = 0; i < MH; i++) begin
        if (hw_mask[i]) begin
          mem[ptr_q + ADDR_WIDTH'(i)] <= hw_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: gather bytes at (addr+i) mod NUM_BYTES, little-endian.
  // ---------------------------------------------------------------------------
  logic [NUM_RD_PORTS*DATA_WIDTH_CPU-1:0] rd_comb;
  logic [DATA_WIDTH_HTIF-1:0]             hr_comb;

  always_comb begin
    rd_comb = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int i = 0; i < MC; i++) begin
        rd_comb[p*DATA_WIDTH_CPU + 8*i +: 8] =
          mem[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(i)];
      end
    end
  end

  always_comb begin
    hr_comb = '0;
    for (int i = 0; i < MH; i++) begin
      hr_comb[8*i +: 8] = mem[hr_addr + ADDR_WIDTH'(i)];
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_rd_async
      assign rd_data = rd_comb;
      assign hr_data = hr_comb;
    end else begin : g_rd_reg
      logic [NUM_RD_PORTS*DATA_WIDTH_CPU-1:0] rd_q;
      logic [DATA_WIDTH_HTIF-1:0]             hr_q;
      // Sampled in the same edge as any write, so a colliding write returns old bytes.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_q <= '0;
          hr_q <= '0;
        end else begin
          rd_q <= rd_comb;
          hr_q <= hr_comb;
        end
      end
      assign rd_data = rd_q;
      assign hr_data = hr_q;
    end
  endgenerate

  // Byte-wide backdoor access for the harness, reached hierarchically.
  function automatic logic [7:0] get_mem(input logic [ADDR_WIDTH-1:0] addr);
    return mem[addr];
  endfunction

  task automatic set_mem(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] data);
    mem[addr] <= data;
  endtask

endmodule
